oam_dma_arbiter: RTL and testbench
==================================

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter OAM_LEN, default 160, bytes per DMA transfer.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, first OAM destination address.
REQ-003 SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have input rst, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have inputs cpu_addr (16 bits), cpu_rd (1), cpu_wr (1) and cpu_wdata (8), carrying the CPU request.
REQ-006 SHALL have outputs cpu_rdata (8 bits, CPU read data) and cpu_stall (1 bit, CPU access not serviced this cycle).
REQ-007 SHALL have inputs ppu_mode (2 bits; 0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW), ppu_rd (1) and ppu_addr (16), carrying the PPU request.
REQ-008 SHALL have output ppu_rdata, 8 bits, PPU read data.
REQ-009 SHALL have outputs mem_addr (16 bits), mem_rd (1), mem_wr (1) and mem_wdata (8), driving the shared memory port.
REQ-010 SHALL have input mem_rdata, 8 bits, valid in the same cycle as mem_rd.
REQ-011 SHALL have output dma_active, 1 bit, high while a transfer is running.

Function
REQ-012 SHALL contain register DMA_SRC (8 bits), written by cpu_wr with cpu_addr==FF46; cpu_rdata SHALL return DMA_SRC for cpu_rd at FF46, and no other register SHALL be provided.
REQ-013 SHALL use FSM states IDLE, START, READ and WRITE.
REQ-014 SHALL transition on an FF46 write: any state -> START next cycle; dma_idx := 0; DMA_SRC := cpu_wdata.
REQ-015 SHALL transition START -> READ after exactly 1 cycle.
REQ-016 SHALL transition READ -> WRITE unconditionally.
REQ-017 SHALL transition WRITE -> READ with dma_idx+1, or WRITE -> IDLE when dma_idx==OAM_LEN-1.
REQ-018 SHALL drive in READ: mem_addr = src_base + dma_idx, mem_rd=1, mem_rdata latched into dma_byte; src_base = {DMA_SRC,8'h00}, or {DMA_SRC-8'h20,8'h00} when DMA_SRC>8'hDF.
REQ-019 SHALL drive in WRITE: mem_addr = OAM_BASE + dma_idx, mem_wr=1, mem_wdata=dma_byte.
REQ-020 SHALL take 2*OAM_LEN+1 cycles per full transfer (321 for default); dma_active high in START/READ/WRITE.
REQ-021 SHALL apply per-cycle priority: DMA (READ/WRITE) > PPU > CPU; START does not own the port.
REQ-022 SHALL, during dma_active, forward CPU accesses to FF80-FFFE normally and answer FF46 reads/writes; all other CPU reads return 8'hFF and writes are dropped, with cpu_stall=0.
REQ-023 SHALL, during dma_active, not forward PPU reads to the memory port, and ppu_rdata SHALL be 8'hFF.
REQ-024 SHALL block CPU access to FE00-FE9F when ppu_mode==2: reads return FF, writes dropped.
REQ-025 SHALL block CPU access to 8000-9FFF and FE00-FE9F when ppu_mode==3: reads return FF, writes dropped.
REQ-026 SHALL forward ppu_rd with no DMA to the port (mem_rd=1, mem_addr=ppu_addr), with ppu_rdata=mem_rdata combinationally; ppu_rdata=FF when not granted.
REQ-027 SHALL, when the PPU is granted and the CPU requests a non-blocked address other than FF46/FF80-FFFE, drop the CPU access and raise cpu_stall=1 for that cycle.
REQ-028 SHALL route a non-blocked CPU access with no higher-priority owner combinationally to the mem port; cpu_rdata=mem_rdata.
REQ-029 SHALL drive mem_rd=mem_wr=0, mem_addr=0 and mem_wdata=0 when no requester owns the port.
REQ-030 SHALL abort an active transfer on an FF46 write in the final WRITE cycle: that final write still occurs, and the restart wins the state update.

Reset
REQ-031 SHALL, with rst high at a clock edge, set state=IDLE, dma_idx=0, dma_byte=0 and DMA_SRC=0, aborting any transfer in progress with no further mem_wr.
REQ-032 SHALL set outputs after reset to: dma_active=0, cpu_stall=0, mem_rd=0, mem_wr=0, ppu_rdata=FF.

Verification
REQ-033 SHALL cover the full copy: write C1 to FF46, memory C100+i = i -> dma_active for 321 cycles; FE00+i = i for i=0..159; last mem_wr at FE9F.
REQ-034 SHALL cover the echo source: write E2 -> READ cycles address C200..C29F.
REQ-035 SHALL cover blocking during DMA: CPU read of C000 -> cpu_rdata=FF; CPU write FF80=5A -> mem_wr at FF80 with data 5A; ppu_rd at FE00 -> ppu_rdata=FF, no mem_rd from the PPU.
REQ-036 SHALL cover mode blocking: ppu_mode=3 with CPU write 8000=AA -> no mem_wr; ppu_mode=0 with the same write -> mem_wr at 8000 with data AA.
REQ-037 SHALL cover restart: write C1, then after 50 cycles write C3 -> START, then READ at C300, dma_idx=0, total 321 cycles from the second write.
REQ-038 SHALL cover reset mid-transfer: assert rst at dma_idx=80 -> dma_active=0 next cycle, no further mem_wr, DMA_SRC reads back 00.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and shared-memory-port arbiter: copies OAM_LEN bytes into OAM
// while arbitrating one memory port between the DMA, the PPU and the CPU.
module oam_dma_arbiter #(
  parameter int          OAM_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W = (OAM_LEN > 1) ? $clog2(OAM_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OAM_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] dma_idx_q, dma_idx_d;
  logic [7:0]       dma_byte_q, dma_byte_d;
  logic [7:0]       dma_src_q, dma_src_d;

  logic        cpu_req;
  logic        hit_reg;
  logic        hit_hram;
  logic        hit_oam;
  logic        hit_vram;
  logic        mode_block;
  logic        cpu_blocked;
  logic        cpu_port_req;
  logic        dma_owns;
  logic        ppu_grant;
  logic        cpu_grant;
  logic [7:0]  src_hi;
  logic [15:0] src_base;

  assign cpu_req  = cpu_rd | cpu_wr;
  assign hit_reg  = (cpu_addr == 16'hFF46);
  assign hit_hram = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign hit_oam  = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
  assign hit_vram = (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF);

  assign dma_active = (state_q != IDLE);
  assign dma_owns   = (state_q == READ) || (state_q == WRITE);
  assign dbg_state  = state_q;

  // Blocked accesses are answered with FF and dropped without stalling.
  assign mode_block   = ((ppu_mode == 2'd2) && hit_oam) ||
                        ((ppu_mode == 2'd3) && (hit_oam || hit_vram));
  assign cpu_blocked  = mode_block || (dma_active && !hit_hram && !hit_reg);
  assign cpu_port_req = cpu_req && !hit_reg && !cpu_blocked;

  assign ppu_grant = ppu_rd && !dma_active;
  assign cpu_grant = cpu_port_req && !dma_owns && !ppu_grant;
  assign cpu_stall = cpu_port_req && !cpu_grant;

  // Sources above DF00 alias down into work RAM (echo region).
  assign src_hi   = (dma_src_q > 8'hDF) ? (dma_src_q - 8'h20) : dma_src_q;
  assign src_base = {src_hi, 8'h00};

  always_comb begin
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    cpu_rdata = 8'hFF;
    ppu_rdata = 8'hFF;
    if (state_q == READ) begin
      mem_addr = src_base + 16'(dma_idx_q);
      mem_rd   = 1'b1;
    end else if (state_q == WRITE) begin
      mem_addr  = OAM_BASE + 16'(dma_idx_q);
      mem_wr    = 1'b1;
      mem_wdata = dma_byte_q;
    end else if (ppu_grant) begin
      mem_addr  = ppu_addr;
      mem_rd    = 1'b1;
      ppu_rdata = mem_rdata;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wdata;
      if (cpu_rd) begin
        cpu_rdata = mem_rdata;
      end
    end
    if (cpu_rd && hit_reg) begin
      cpu_rdata = dma_src_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    dma_idx_d  = dma_idx_q;
    dma_byte_d = dma_byte_q;
    dma_src_d  = dma_src_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      START: state_d = READ;
      READ: begin
        dma_byte_d = mem_rdata;
        state_d    = WRITE;
      end
      WRITE: begin
        if (dma_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          dma_idx_d = '0;
        end else begin
          state_d   = READ;
          dma_idx_d = dma_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A DMA_SRC write restarts from any state and overrides the step above.
    if (cpu_wr && hit_reg) begin
      state_d   = START;
      dma_idx_d = '0;
      dma_src_d = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dma_idx_q  <= '0;
      dma_byte_q <= 8'h00;
      dma_src_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      dma_idx_q  <= dma_idx_d;
      dma_byte_q <= dma_byte_d;
      dma_src_q  <= dma_src_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: a byte-array memory model behind the port and a
// queue of expected memory writes that is checked as the DUT writes.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [1:0]  ppu_mode;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          unexp_wr = 0;
  logic [15:0] last_wr_addr = 16'h0000;

  int          cnt;
  logic [15:0] first_rd;
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ppu_mode   (ppu_mode),
    .ppu_rd     (ppu_rd),
    .ppu_addr   (ppu_addr),
    .ppu_rdata  (ppu_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory side of the scoreboard: apply and compare every write seen.
  task automatic mon_step();
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      last_wr_addr  = mem_addr;
      if (exp_q.size() > 0) begin
        check("mem_wr", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_q.pop_front()});
      end else begin
        unexp_wr++;
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon_step();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  task automatic set_idle();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    ppu_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
  endtask

  task automatic push_copy(input logic [15:0] src, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa;
      sa = src + 16'(i);
      exp_q.push_back({16'hFE00 + 16'(i), mem[sa]});
    end
  endtask

  // Counts active cycles until dma_active falls, bounded to 400 cycles.
  task automatic run_dma(output int n, output logic [15:0] f_rd, output logic [15:0] l_rd);
    logic seen;
    n    = 0;
    seen = 1'b0;
    f_rd = 16'h0000;
    l_rd = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      half();
      if (dma_active) begin
        n++;
        if (mem_rd) begin
          if (!seen) f_rd = mem_addr;
          seen = 1'b1;
          l_rd = mem_addr;
        end
      end else if (n > 0) begin
        fin();
        return;
      end
      fin();
    end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    ppu_mode  = 2'd0;
    ppu_addr  = 16'h0000;
    set_idle();
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC100 + 16'(i)] = 8'(i);
      mem[16'hC200 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hE200 + 16'(i)] = 8'hEE;
      mem[16'hC300 + 16'(i)] = 8'(i) + 8'h40;
    end
    mem[16'h8005] = 8'h77;
    mem[16'h8010] = 8'h3C;

    // Reset state
    cyc();
    half();
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_ppu_rdata", 32'(ppu_rdata), 32'hFF);
    check("rst_state", 32'(dbg_state), 32'd0);
    fin();
    rst = 1'b0;
    cpu_read(16'hFF46);
    half();
    check("rst_src", 32'(cpu_rdata), 32'h00);
    check("reg_rd_no_port", 32'(mem_rd), 32'd0);
    fin();
    set_idle();

    // Full copy from C100
    push_copy(16'hC100, 160);
    cpu_write(16'hFF46, 8'hC1);
    cyc();
    set_idle();
    run_dma(cnt, first_rd, last_rd);
    check("copy_cycles", 32'(cnt), 32'd321);
    check("copy_first_rd", 32'(first_rd), 32'hC100);
    check("copy_last_wr", 32'(last_wr_addr), 32'hFE9F);
    check("copy_fe00", 32'(mem[16'hFE00]), 32'h00);
    check("copy_fe9f", 32'(mem[16'hFE9F]), 32'h9F);
    cpu_read(16'hFF46);
    half();
    check("src_readback", 32'(cpu_rdata), 32'hC1);
    fin();
    set_idle();

    // Echo source E2 reads C200..C29F
    push_copy(16'hC200, 160);
    cpu_write(16'hFF46, 8'hE2);
    cyc();
    set_idle();
    run_dma(cnt, first_rd, last_rd);
    check("echo_cycles", 32'(cnt), 32'd321);
    check("echo_first_rd", 32'(first_rd), 32'hC200);
    check("echo_last_rd", 32'(last_rd), 32'hC29F);

    // Blocking while the DMA runs
    exp_q.push_back({16'hFF80, 8'h5A});
    push_copy(16'hC100, 160);
    cpu_write(16'hFF46, 8'hC1);
    cyc();
    cpu_write(16'hFF80, 8'h5A);
    half();
    check("hram_start_active", 32'(dma_active), 32'd1);
    check("hram_start_stall", 32'(cpu_stall), 32'd0);
    fin();
    set_idle();
    repeat (3) cyc();
    cpu_read(16'hC000);
    half();
    check("dma_cpu_rd_ff", 32'(cpu_rdata), 32'hFF);
    check("dma_cpu_rd_stall", 32'(cpu_stall), 32'd0);
    fin();
    cpu_write(16'hC000, 8'h77);
    half();
    check("dma_cpu_wr_drop", 32'(mem_wr && mem_addr == 16'hC000), 32'd0);
    check("dma_cpu_wr_stall", 32'(cpu_stall), 32'd0);
    fin();
    set_idle();
    ppu_rd   = 1'b1;
    ppu_addr = 16'hFE00;
    half();
    check("dma_ppu_rdata", 32'(ppu_rdata), 32'hFF);
    check("dma_ppu_no_rd", 32'(mem_rd && mem_addr == 16'hFE00), 32'd0);
    fin();
    set_idle();
    run_dma(cnt, first_rd, last_rd);
    check("blk_done", 32'(dma_active), 32'd0);

    // PPU mode blocking with the port otherwise free
    ppu_mode = 2'd3;
    cpu_read(16'h8000);
    half();
    check("m3_vram_rd", 32'(cpu_rdata), 32'hFF);
    fin();
    cpu_write(16'h8000, 8'hAA);
    half();
    check("m3_vram_wr", 32'(mem_wr), 32'd0);
    check("m3_vram_stall", 32'(cpu_stall), 32'd0);
    fin();
    ppu_mode = 2'd2;
    cpu_read(16'hFE10);
    half();
    check("m2_oam_rd", 32'(cpu_rdata), 32'hFF);
    fin();
    cpu_read(16'h8005);
    half();
    check("m2_vram_rd", 32'(cpu_rdata), 32'h77);
    fin();
    ppu_mode = 2'd0;
    exp_q.push_back({16'h8000, 8'hAA});
    cpu_write(16'h8000, 8'hAA);
    half();
    check("m0_vram_wr", 32'(mem_wr), 32'd1);
    fin();
    set_idle();

    // PPU granted, CPU to work RAM is stalled, FF46 still answered
    ppu_rd   = 1'b1;
    ppu_addr = 16'h8010;
    cpu_read(16'hC105);
    half();
    check("ppu_rdata", 32'(ppu_rdata), 32'h3C);
    check("ppu_cpu_stall", 32'(cpu_stall), 32'd1);
    check("ppu_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    fin();
    cpu_read(16'hFF46);
    half();
    check("ppu_reg_stall", 32'(cpu_stall), 32'd0);
    check("ppu_reg_rdata", 32'(cpu_rdata), 32'hC1);
    fin();
    set_idle();
    cpu_read(16'hC105);
    half();
    check("cpu_rd_free", 32'(cpu_rdata), 32'h05);
    fin();
    set_idle();

    // Restart during the final WRITE: that write lands, then a new START
    push_copy(16'hC100, 160);
    push_copy(16'hC300, 160);
    cpu_write(16'hFF46, 8'hC1);
    cyc();
    set_idle();
    repeat (320) cyc();
    cpu_write(16'hFF46, 8'hC3);
    half();
    check("final_wr_addr", 32'(mem_addr), 32'hFE9F);
    fin();
    set_idle();
    half();
    check("final_restart_state", 32'(dbg_state), 32'd1);
    fin();
    run_dma(cnt, first_rd, last_rd);
    check("final_restart_cycles", 32'(cnt + 1), 32'd321);
    check("final_restart_rd", 32'(first_rd), 32'hC300);

    // Restart 50 cycles in: 24 bytes of the first transfer land first
    push_copy(16'hC100, 24);
    push_copy(16'hC300, 160);
    cpu_write(16'hFF46, 8'hC1);
    cyc();
    set_idle();
    repeat (49) cyc();
    cpu_write(16'hFF46, 8'hC3);
    half();
    check("restart_pre_rd", 32'(mem_addr), 32'hC118);
    fin();
    set_idle();
    half();
    check("restart_state", 32'(dbg_state), 32'd1);
    fin();
    half();
    check("restart_rd_addr", 32'(mem_addr), 32'hC300);
    check("restart_rd", 32'(mem_rd), 32'd1);
    fin();
    run_dma(cnt, first_rd, last_rd);
    check("restart_cycles", 32'(cnt + 2), 32'd321);

    // Reset at dma_idx 80
    push_copy(16'hC100, 80);
    cpu_write(16'hFF46, 8'hC1);
    cyc();
    set_idle();
    repeat (161) cyc();
    rst = 1'b1;
    half();
    check("rst_mid_rd_addr", 32'(mem_addr), 32'hC150);
    fin();
    rst = 1'b0;
    half();
    check("rst_mid_active", 32'(dma_active), 32'd0);
    check("rst_mid_wr", 32'(mem_wr), 32'd0);
    fin();
    repeat (20) cyc();
    cpu_read(16'hFF46);
    half();
    check("rst_mid_src", 32'(cpu_rdata), 32'h00);
    fin();
    set_idle();

    check("unexpected_writes", 32'(unexp_wr), 32'd0);
    check("missing_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
